// File: rtl/imm_encoder.sv
// Packs RV32I instruction fields plus a range-checked immediate into a 32-bit word.
// Latency: 1 cycle from accept to out_valid_o / err_o.
// Backpressure: in_ready_o drops while a held word is stalled by out_ready_i.
module imm_encoder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [2:0]    fmt_i,
    input  logic [6:0]    opcode_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic [2:0]    funct3_i,
    input  logic [6:0]    funct7_i,
    input  logic [31:0]   imm_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   instr_data_o,
    output logic [AW-1:0] addr_o,
    output logic          err_o,
    output logic [7:0]    err_cnt_o
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic        accept;
    logic        out_fire;
    logic        imm_ok;
    logic        legal;
    logic        load_word;
    logic        reject;
    logic [31:0] packed_word;

    // Sign-extension checks: the upper bits must all be copies of the top encoded bit.
    logic sext_12;
    logic sext_13;
    logic sext_21;

    assign sext_12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign sext_13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign sext_21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_o && out_ready_i;

    always_comb begin
        imm_ok      = 1'b0;
        packed_word = 32'd0;
        case (fmt_e'(fmt_i))
            FMT_R: begin
                imm_ok      = 1'b1;
                packed_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                imm_ok      = sext_12;
                packed_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_S: begin
                imm_ok      = sext_12;
                packed_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            FMT_B: begin
                imm_ok      = sext_13 && !imm_i[0];
                packed_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
            end
            FMT_J: begin
                imm_ok      = sext_21 && !imm_i[0];
                packed_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                               rd_i, opcode_i};
            end
            default: begin
                imm_ok      = 1'b0;
                packed_word = 32'd0;
            end
        endcase
    end

    assign legal     = imm_ok && (opcode_i[1:0] == 2'b11);
    // A flush swallows the same-cycle input entirely: neither loaded nor counted.
    assign load_word = accept && legal && !flush_i;
    assign reject    = accept && !legal && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_o  <= 1'b0;
            instr_data_o <= 32'd0;
            addr_o       <= '0;
        end else if (flush_i) begin
            out_valid_o  <= 1'b0;
            addr_o       <= '0;
        end else begin
            if (out_fire) begin
                addr_o <= (addr_o == LAST_ADDR) ? '0 : addr_o + 1'b1;
            end
            if (load_word) begin
                out_valid_o  <= 1'b1;
                instr_data_o <= packed_word;
            end else if (out_fire) begin
                out_valid_o  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= 8'd0;
        end else begin
            err_o <= reject;
            if (reject && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table plus stall, flush, reset and saturation sequences.
module tb_imm_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr_data;
    logic [AW-1:0] addr;
    logic          err;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    imm_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .fmt_i        (fmt),
        .opcode_i     (opcode),
        .rd_i         (rd),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .funct3_i     (funct3),
        .funct7_i     (funct7),
        .imm_i        (imm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .instr_data_o (instr_data),
        .addr_o       (addr),
        .err_o        (err),
        .err_cnt_o    (err_cnt)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[13];
    int total = 0;
    int bad   = 0;
    int exp_cnt;
    int exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_i(input logic [31:0] v_imm);
        fmt = 3'd1; opcode = 7'b0010011; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = v_imm;
    endtask

    logic [31:0] held_word;
    logic [AW-1:0] held_addr;

    initial begin
        // fmt, opcode, rd, rs1, rs2, f3, f7, imm, legal, word
        vecs[0]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd5,         1'b1, 32'h00500093};
        vecs[1]  = '{3'd2, 7'b0100011, 5'd0, 5'd0, 5'd2, 3'd2, 7'd0,    32'd8,         1'b1, 32'h00202423};
        vecs[2]  = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFC,  1'b1, 32'hFE000EE3};
        vecs[3]  = '{3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd8,         1'b1, 32'h008000EF};
        vecs[4]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2047,      1'b1, 32'h7FF00093};
        vecs[5]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFF800,  1'b1, 32'h80000093};
        vecs[6]  = '{3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd2048,      1'b0, 32'h0};
        vecs[7]  = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd3,         1'b0, 32'h0};
        vecs[8]  = '{3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd0,         1'b0, 32'h0};
        vecs[9]  = '{3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20,   32'hDEADBEEF,  1'b1, 32'h403100B3};
        vecs[10] = '{3'd1, 7'b0010000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd1,         1'b0, 32'h0};
        vecs[11] = '{3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00100000,  1'b0, 32'h0};
        vecs[12] = '{3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'd4094,      1'b1, 32'h7E000FE3};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        drive_i(32'd5);
        #3;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_instr", instr_data, 32'd0);
        chk("reset_addr", {30'd0, addr}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        #4 rst_n = 1'b1;
        step();

        // Vector table: one vector every two cycles, output drained immediately.
        exp_cnt  = 0;
        exp_addr = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            fmt = vecs[i].fmt; opcode = vecs[i].opcode; rd = vecs[i].rd;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; funct3 = vecs[i].f3;
            funct7 = vecs[i].f7; imm = vecs[i].imm;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (!vecs[i].legal) exp_cnt++;
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].legal});
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, !vecs[i].legal});
            chk($sformatf("vec%0d_err_cnt", i), {24'd0, err_cnt}, exp_cnt);
            if (vecs[i].legal) begin
                chk($sformatf("vec%0d_word", i), instr_data, vecs[i].word);
                chk($sformatf("vec%0d_addr", i), {30'd0, addr}, exp_addr);
                exp_addr = (exp_addr + 1) % DEPTH;
            end
            step();
            chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("vec%0d_err_clear", i), {31'd0, err}, 32'd0);
        end

        // Backpressure: word A held five cycles, then B and C flow back-to-back.
        out_ready = 1'b0;
        drive_i(32'd1);
        in_valid = 1'b1;
        step();
        drive_i(32'd2);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_word", c), instr_data, 32'h00100093);
            chk($sformatf("stall%0d_addr", c), {30'd0, addr}, exp_addr);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        exp_addr = (exp_addr + 1) % DEPTH;
        chk("release_word_b", instr_data, 32'h00200093);
        chk("release_addr_b", {30'd0, addr}, exp_addr);
        chk("release_valid_b", {31'd0, out_valid}, 32'd1);
        drive_i(32'd3);
        step();
        in_valid = 1'b0;
        exp_addr = (exp_addr + 1) % DEPTH;
        chk("release_word_c", instr_data, 32'h00300093);
        chk("release_addr_c", {30'd0, addr}, exp_addr);
        chk("release_valid_c", {31'd0, out_valid}, 32'd1);
        step();
        exp_addr = (exp_addr + 1) % DEPTH;
        chk("release_drained", {31'd0, out_valid}, 32'd0);
        chk("release_addr_end", {30'd0, addr}, exp_addr);

        // Flush with an illegal input: held word dropped, address cleared, no error.
        out_ready = 1'b0;
        drive_i(32'd7);
        in_valid = 1'b1;
        step();
        chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        drive_i(32'd4096);
        flush = 1'b1;
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_addr", {30'd0, addr}, 32'd0);
        chk("flush_err", {31'd0, err}, 32'd0);
        chk("flush_err_cnt", {24'd0, err_cnt}, exp_cnt);
        drive_i(32'd9);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_legal_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_legal_addr", {30'd0, addr}, 32'd0);
        step();
        chk("post_flush_err", {31'd0, err}, 32'd0);

        // Reset pulsed in the middle of a stall.
        out_ready = 1'b0;
        drive_i(32'd10);
        in_valid = 1'b1;
        step();
        step();
        held_word = instr_data;
        held_addr = addr;
        chk("midstall_word", held_word, 32'h00A00093);
        chk("midstall_addr", {30'd0, held_addr}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_instr", instr_data, 32'd0);
        chk("arst_addr", {30'd0, addr}, 32'd0);
        chk("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("post_arst_valid", {31'd0, out_valid}, 32'd0);

        // Error saturation: 260 back-to-back illegal inputs.
        out_ready = 1'b1;
        drive_i(32'd0);
        fmt = 3'd7;
        in_valid = 1'b1;
        exp_cnt = 0;
        for (int k = 0; k < 260; k++) begin
            step();
            if (exp_cnt < 255) exp_cnt++;
            chk($sformatf("sat%0d_err", k), {31'd0, err}, 32'd1);
            chk($sformatf("sat%0d_cnt", k), {24'd0, err_cnt}, exp_cnt);
        end
        in_valid = 1'b0;
        step();
        chk("sat_final_cnt", {24'd0, err_cnt}, 32'd255);
        chk("sat_final_err", {31'd0, err}, 32'd0);
        chk("sat_no_output", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
